aes_shiftrow_pipe: RTL

AES_SHIFTROW_PIPE -- requirements
Module: aes_shiftrow_pipe

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_row_rotate.sv | 28 ++
 rtl/aes_shiftrow_pipe.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared helpers for the AES ShiftRows datapath.
//   shift_ofs(nb, r) : row rotation offset for an nb-column state
//   byte_idx(r, c)   : column-major byte index (byte 0 sits at the MSBs)
//   nb_legal(nb)     : true for the supported column counts 4, 6 and 8
package aes_pkg;

  localparam int unsigned NumRows = 4;

  // Rijndael offsets: {0,1,2,3} for 4/6 columns, {0,1,3,4} for 8 columns.
  function automatic int unsigned shift_ofs(input int unsigned nb, input int unsigned r);
    int unsigned ofs;
    ofs = r;
    if (nb == 8 && r >= 2) begin
      ofs = r + 1;
    end
    return ofs;
  endfunction

  function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
    return r + NumRows * c;
  endfunction

  function automatic bit nb_legal(input int unsigned nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

endpackage

// File: rtl/aes_row_rotate.sv
// aes_row_rotate: purely combinational NB-column ShiftRows permutation for one direction.
//   NB      : state column count
//   DEC     : 0 = ShiftRows (out(r,c) = in(r,c+s)), 1 = InvShiftRows (out(r,c) = in(r,c-s))
//   state_i : input state, column-major, byte 0 at the MSBs
//   state_o : permuted state
module aes_row_rotate
  import aes_pkg::*;
#(
  parameter int unsigned  NB  = 4,
  parameter bit           DEC = 1'b0,
  localparam int unsigned W   = 32 * NB
) (
  input  logic [W-1:0] state_i,
  output logic [W-1:0] state_o
);

  for (genvar r = 0; r < NumRows; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int unsigned Ofs     = shift_ofs(NB, r);
      // Adding NB before subtracting keeps the inverse index non-negative.
      localparam int unsigned SrcCol  = DEC ? (c + NB - Ofs) % NB : (c + Ofs) % NB;
      localparam int unsigned DstByte = byte_idx(r, c);
      localparam int unsigned SrcByte = byte_idx(r, SrcCol);
      assign state_o[W-1-8*DstByte -: 8] = state_i[W-1-8*SrcByte -: 8];
    end
  end

endmodule

// File: rtl/aes_shiftrow_pipe.sv
// aes_shiftrow_pipe: valid/ready pipelined AES ShiftRows / InvShiftRows stage.
//   Parameters: NB (4, 6 or 8 columns), REG_IN (1 adds an input register stage).
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid / in_ready : input handshake; in_ready comes only from registered occupancy
//     in_dec              : 0 = ShiftRows, 1 = InvShiftRows, travels with its transaction
//     in_data             : input state (W = 32*NB bits)
//     out_valid/out_ready : output handshake from a 2-entry skid buffer
//     out_data            : transformed state (head of the buffer)
//   Build macro AES_SHIFTROW_INV_EN: when defined, in_dec selects the inverse permutation;
//   otherwise in_dec is ignored and only the forward permutation is built.
module aes_shiftrow_pipe
  import aes_pkg::*;
#(
  parameter int unsigned  NB     = 4,
  parameter int unsigned  REG_IN = 0,
  localparam int unsigned W      = 32 * NB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dec,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $fatal(1, "aes_shiftrow_pipe: NB must be 4, 6 or 8");
  end

  logic         src_valid;
  logic         src_dec;
  logic [W-1:0] src_data;
  logic [W-1:0] xf_data;
  logic         push;
  logic         pop;

  logic [1:0]   count_q, count_d;
  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = ent0_q;
  assign pop       = out_valid & out_ready;
  // The buffer only takes a new entry while it has room, so a push never meets a full buffer.
  assign push      = src_valid & in_ready;

  // Optional input register stage.
  if (REG_IN != 0) begin : g_reg_in
    logic         stg_valid_q;
    logic         stg_dec_q;
    logic [W-1:0] stg_data_q;

    // Whenever in_ready is high the stage drains into the buffer, so loading it is safe.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_valid_q <= 1'b0;
        stg_dec_q   <= 1'b0;
        stg_data_q  <= '0;
      end else if (in_valid && in_ready) begin
        stg_valid_q <= 1'b1;
        stg_dec_q   <= in_dec;
        stg_data_q  <= in_data;
      end else if (push) begin
        stg_valid_q <= 1'b0;
      end
    end

    assign src_valid = stg_valid_q;
    assign src_dec   = stg_dec_q;
    assign src_data  = stg_data_q;
  end else begin : g_no_reg_in
    assign src_valid = in_valid;
    assign src_dec   = in_dec;
    assign src_data  = in_data;
  end

`ifdef AES_SHIFTROW_INV_EN
  logic [W-1:0] enc_data;
  logic [W-1:0] dec_data;

  aes_row_rotate #(
    .NB  (NB),
    .DEC (1'b0)
  ) u_rot_enc (
    .state_i (src_data),
    .state_o (enc_data)
  );

  aes_row_rotate #(
    .NB  (NB),
    .DEC (1'b1)
  ) u_rot_dec (
    .state_i (src_data),
    .state_o (dec_data)
  );

  assign xf_data = src_dec ? dec_data : enc_data;
`else
  aes_row_rotate #(
    .NB  (NB),
    .DEC (1'b0)
  ) u_rot_enc (
    .state_i (src_data),
    .state_o (xf_data)
  );

  // Mode is carried but has no consumer in the forward-only build.
  logic unused_dec;
  assign unused_dec = src_dec;
`endif

  // Two-entry skid buffer; ent0 is always the head presented on out_data.
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          ent0_d = xf_data;
        end else begin
          ent1_d = xf_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // push implies count < 2 and pop implies count > 0: exactly one entry, replace it.
        ent0_d = xf_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

endmodule
